fifo_sram_packed: RTL and testbench

//  Next-generation AXIS-side FIFO backed by an external single-port SRAM. Packs PACK words per SRAM row
//  (previous generation was fixed at 2), applies real full/empty flow control with gated writes, and reports

---
 rtl/fifo_sram_packed.sv | 137 +++++++++++++
 tb/tb_fifo_sram_packed.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sram_packed.sv
// Stream FIFO over a single-port SRAM: PACK words per row, staged write row, one-row read buffer
// with fetch bypass so a reader can drain one word per cycle.
module fifo_sram_packed #(
  parameter int unsigned WIDTH   = 45,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned PACK    = 2,
  parameter int unsigned SRAM_DW = 100,
  parameter int unsigned TH_W    = 8,
  localparam int unsigned LW     = $clog2(DEPTH * PACK) + 1,
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic               axis_clk,
  input  logic               axi_reset_n,
  input  logic               w_vld,
  output logic               w_rdy,
  input  logic [WIDTH-1:0]   data_in,
  input  logic               r_rdy,
  output logic               r_vld,
  output logic [WIDTH-1:0]   data_out,
  input  logic [TH_W-1:0]    TH_reg,
  output logic [LW-1:0]      level,
  output logic               above_th,
  output logic               sram_we,
  output logic               sram_re,
  output logic [AW-1:0]      sram_addr,
  output logic [SRAM_DW-1:0] sram_din,
  input  logic [SRAM_DW-1:0] sram_dout
);

  localparam int unsigned CAP = DEPTH * PACK;
  localparam int unsigned IW  = $clog2(PACK);
  localparam int unsigned RW  = LW - IW;
  localparam int unsigned CW  = (LW > TH_W) ? LW : TH_W;

  logic [LW-1:0]      wptr_q, rptr_q;
  logic [WIDTH-1:0]   wbuf_q [PACK];
  logic [SRAM_DW-1:0] rbuf_q, din_q, row_w;
  logic [RW-1:0]      rbuf_row_q, pend_row_q;
  logic               rbuf_vld_q, pend_q;

  // Row ids keep the wrap bit so a row from the previous lap never aliases the current one.
  logic [RW-1:0] wrow, rrow, fetch_row;
  logic [IW-1:0] widx, ridx;
  logic          full, empty, wr_en, rd_en, commit, fetch_req;
  logic          src_stage, src_byp, src_rbuf;

  assign wrow  = wptr_q[LW-1:IW];
  assign rrow  = rptr_q[LW-1:IW];
  assign widx  = wptr_q[IW-1:0];
  assign ridx  = rptr_q[IW-1:0];
  assign level = wptr_q - rptr_q;
  assign full  = (level == LW'(CAP));
  assign empty = (level == '0);

  assign above_th = CW'(level) > CW'(TH_reg);

  assign w_rdy  = axi_reset_n & ~full;
  assign wr_en  = w_vld & w_rdy;
  assign commit = wr_en & (widx == IW'(PACK - 1));

  always_comb begin
    row_w = '0;
    for (int i = 0; i < PACK - 1; i++) begin
      row_w[i*WIDTH +: WIDTH] = wbuf_q[i];
    end
    row_w[(PACK-1)*WIDTH +: WIDTH] = data_in;
  end

  assign src_stage = ~empty & (rrow == wrow);
  assign src_byp   = pend_q & (pend_row_q == rrow);
  assign src_rbuf  = rbuf_vld_q & (rbuf_row_q == rrow);

  always_comb begin
    data_out = '0;
    if (src_stage) begin
      data_out = wbuf_q[ridx];
    end else if (src_byp) begin
      data_out = sram_dout[int'(ridx)*WIDTH +: WIDTH];
    end else if (src_rbuf) begin
      data_out = rbuf_q[int'(ridx)*WIDTH +: WIDTH];
    end
  end

  assign r_vld = axi_reset_n & ~empty & (src_stage | src_byp | src_rbuf);
  assign rd_en = r_vld & r_rdy;

  // Popping the last word of a row looks one row ahead so the next row arrives via bypass.
  assign fetch_row = (rd_en && (ridx == IW'(PACK - 1))) ? rrow + RW'(1) : rrow;
  assign fetch_req = (fetch_row != wrow)
                   & ~(rbuf_vld_q & (rbuf_row_q == fetch_row))
                   & ~(pend_q & (pend_row_q == fetch_row));

  assign sram_we   = commit;
  assign sram_re   = axi_reset_n & fetch_req & ~commit;
  assign sram_addr = commit  ? wrow[AW-1:0] :
                     sram_re ? fetch_row[AW-1:0] : rrow[AW-1:0];
  assign sram_din  = commit ? row_w : din_q;

  always_ff @(posedge axis_clk) begin
    if (!axi_reset_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      din_q      <= '0;
      rbuf_q     <= '0;
      rbuf_row_q <= '0;
      rbuf_vld_q <= 1'b0;
      pend_row_q <= '0;
      pend_q     <= 1'b0;
    end else begin
      if (wr_en) begin
        wbuf_q[widx] <= data_in;
        wptr_q       <= wptr_q + LW'(1);
      end
      if (rd_en) begin
        rptr_q <= rptr_q + LW'(1);
      end
      if (commit) begin
        din_q <= row_w;
      end
      pend_q <= sram_re;
      if (sram_re) begin
        pend_row_q <= fetch_row;
      end
      // Write-through wins: a returning fetch here can only be for a row the reader has left.
      if (commit && (rrow == wrow)) begin
        rbuf_q     <= row_w;
        rbuf_row_q <= wrow;
        rbuf_vld_q <= 1'b1;
      end else if (pend_q) begin
        rbuf_q     <= sram_dout;
        rbuf_row_q <= pend_row_q;
        rbuf_vld_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_sram_packed.sv
// Self-checking bench: two DUTs (PACK=2 and PACK=4) share stimulus; scoreboards check order and
// level every cycle, a vector table and hand sequences check the corner cases.
module tb_fifo_sram_packed;

  localparam int unsigned WIDTH = 45, DEPTH = 16, PACK = 2, SRAM_DW = 100, TH_W = 8;
  localparam int unsigned LW = 6, AW = 4, CAP = 32;
  localparam int unsigned BW = 16, BPACK = 4, BDW = 64, BLW = 7, BCAP = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n = 1'b0, w_vld = 1'b0, r_rdy = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic [TH_W-1:0]  th_reg = 8'd5;

  logic               w_rdy, r_vld, above_th, sram_we, sram_re;
  logic [WIDTH-1:0]   data_out;
  logic [LW-1:0]      level;
  logic [AW-1:0]      sram_addr;
  logic [SRAM_DW-1:0] sram_din, sram_dout;

  logic           b_w_rdy, b_r_vld, b_above, b_sram_we, b_sram_re;
  logic [BW-1:0]  b_data_out;
  logic [BLW-1:0] b_level;
  logic [AW-1:0]  b_sram_addr;
  logic [BDW-1:0] b_sram_din, b_sram_dout;

  fifo_sram_packed #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PACK(PACK), .SRAM_DW(SRAM_DW), .TH_W(TH_W))
  dut_a (
    .axis_clk(clk), .axi_reset_n(rst_n), .w_vld(w_vld), .w_rdy(w_rdy), .data_in(data_in),
    .r_rdy(r_rdy), .r_vld(r_vld), .data_out(data_out), .TH_reg(th_reg), .level(level),
    .above_th(above_th), .sram_we(sram_we), .sram_re(sram_re), .sram_addr(sram_addr),
    .sram_din(sram_din), .sram_dout(sram_dout)
  );

  fifo_sram_packed #(.WIDTH(BW), .DEPTH(DEPTH), .PACK(BPACK), .SRAM_DW(BDW), .TH_W(TH_W))
  dut_b (
    .axis_clk(clk), .axi_reset_n(rst_n), .w_vld(w_vld), .w_rdy(b_w_rdy),
    .data_in(data_in[BW-1:0]), .r_rdy(r_rdy), .r_vld(b_r_vld), .data_out(b_data_out),
    .TH_reg(th_reg), .level(b_level), .above_th(b_above), .sram_we(b_sram_we),
    .sram_re(b_sram_re), .sram_addr(b_sram_addr), .sram_din(b_sram_din),
    .sram_dout(b_sram_dout)
  );

  logic [SRAM_DW-1:0] mem_a [DEPTH];
  logic [BDW-1:0]     mem_b [DEPTH];

  always @(posedge clk) begin
    if (sram_we) mem_a[sram_addr] <= sram_din;
    else if (sram_re) sram_dout <= mem_a[sram_addr];
    if (b_sram_we) mem_b[b_sram_addr] <= b_sram_din;
    else if (b_sram_re) b_sram_dout <= mem_b[b_sram_addr];
  end

  int checks = 0, errors = 0, pops = 0, we_cnt = 0;
  logic [WIDTH-1:0] q [$];
  logic [BW-1:0]    bq [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Scoreboards: pop-compare first, then record accepted writes.
  always @(negedge clk) begin
    logic [WIDTH-1:0] ea;
    logic [BW-1:0]    eb;
    if (!rst_n) begin
      q.delete();
      bq.delete();
      chk("rst_w_rdy", 64'(w_rdy), 64'(0));
      chk("rst_r_vld", 64'(r_vld), 64'(0));
      chk("rst_sram_we", 64'(sram_we), 64'(0));
      chk("rst_sram_re", 64'(sram_re), 64'(0));
      chk("rst_b_r_vld", 64'(b_r_vld), 64'(0));
    end else begin
      chk("level", 64'(level), 64'(q.size()));
      chk("w_rdy", 64'(w_rdy), 64'(q.size() != CAP));
      chk("above_th", 64'(above_th), 64'(q.size() > int'(th_reg)));
      chk("we_re_excl", 64'(sram_we & sram_re), 64'(0));
      chk("b_level", 64'(b_level), 64'(bq.size()));
      chk("b_w_rdy", 64'(b_w_rdy), 64'(bq.size() != BCAP));
      chk("b_above_th", 64'(b_above), 64'(bq.size() > int'(th_reg)));
      chk("b_we_re_excl", 64'(b_sram_we & b_sram_re), 64'(0));
      if (sram_we) we_cnt++;
      if (r_vld && r_rdy) begin
        pops++;
        if (q.size() == 0) chk("pop_when_empty", 64'(r_vld), 64'(0));
        else begin
          ea = q.pop_front();
          chk("data_out", 64'(data_out), 64'(ea));
        end
      end
      if (b_r_vld && r_rdy) begin
        if (bq.size() == 0) chk("b_pop_when_empty", 64'(b_r_vld), 64'(0));
        else begin
          eb = bq.pop_front();
          chk("b_data_out", 64'(b_data_out), 64'(eb));
        end
      end
      if (w_vld && w_rdy) q.push_back(data_in);
      if (w_vld && b_w_rdy) bq.push_back(data_in[BW-1:0]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    w_vld = 1'b0;
    r_rdy = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic drain(input string nm);
    r_rdy = 1'b1;
    for (int c = 0; c < 200 && (q.size() != 0 || bq.size() != 0); c++) @(negedge clk);
    chk(nm, 64'(q.size() + bq.size()), 64'(0));
  endtask

  typedef struct {
    logic             wv;
    logic [WIDTH-1:0] d;
    logic             rr;
    logic             ev;
    logic [WIDTH-1:0] ed;
    logic [LW-1:0]    el;
    logic             ewe;
    logic             ere;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int we0, p0, k, got, gap;
    logic started;
    tbl[0] = '{1'b1, 45'd0, 1'b0, 1'b0, 45'd0, 6'd0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 45'd1, 1'b0, 1'b1, 45'd0, 6'd1, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 45'd2, 1'b0, 1'b1, 45'd0, 6'd2, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 45'd0, 1'b1, 1'b1, 45'd0, 6'd3, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 45'd0, 1'b1, 1'b1, 45'd1, 6'd2, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 45'd0, 1'b1, 1'b1, 45'd2, 6'd1, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 45'd0, 1'b0, 1'b0, 45'd0, 6'd0, 1'b0, 1'b0};

    do_reset();

    // Push 3, pop 3: one row commit, in-order data.
    we0 = we_cnt;
    for (int i = 0; i < 7; i++) begin
      tick();
      w_vld = tbl[i].wv;
      data_in = tbl[i].d;
      r_rdy = tbl[i].rr;
      @(negedge clk);
      chk("t1_r_vld", 64'(r_vld), 64'(tbl[i].ev));
      if (tbl[i].ev) chk("t1_data", 64'(data_out), 64'(tbl[i].ed));
      chk("t1_level", 64'(level), 64'(tbl[i].el));
      chk("t1_sram_we", 64'(sram_we), 64'(tbl[i].ewe));
      chk("t1_sram_re", 64'(sram_re), 64'(tbl[i].ere));
    end
    chk("t1_we_pulses", 64'(we_cnt - we0), 64'(1));

    // Fill to capacity, extra writes ignored, then drain without gaps.
    for (int i = 0; i < CAP; i++) begin
      tick();
      w_vld = 1'b1;
      data_in = WIDTH'({$urandom(), $urandom()});
    end
    tick();
    data_in = '1;
    @(negedge clk);
    chk("t2_full_w_rdy", 64'(w_rdy), 64'(0));
    chk("t2_full_level", 64'(level), 64'(CAP));
    repeat (2) tick();
    tick();
    w_vld = 1'b0;
    r_rdy = 1'b1;
    got = 0;
    gap = 0;
    started = 1'b0;
    for (int c = 0; c < 100 && got < int'(CAP); c++) begin
      @(negedge clk);
      if (r_vld) begin
        got++;
        started = 1'b1;
      end else if (started) gap++;
    end
    chk("t2_drained", 64'(got), 64'(CAP));
    chk("t2_gaps", 64'(gap), 64'(0));

    // Continuous streaming of 200 words across pointer wrap.
    tick();
    p0 = pops;
    k = 0;
    w_vld = 1'b1;
    r_rdy = 1'b1;
    data_in = WIDTH'(32'h5000);
    for (int c = 0; c < 1000 && k < 200; c++) begin
      @(negedge clk);
      if (w_vld && w_rdy) k++;
      tick();
      w_vld = (k < 200);
      data_in = WIDTH'(32'h5000 + k * 7);
    end
    chk("t3_pushed", 64'(k), 64'(200));
    drain("t3_drained");
    chk("t3_pops", 64'(pops - p0), 64'(200));

    // Reader pops idx0 while the row commits: next word comes from rbuf immediately.
    do_reset();
    tick();
    w_vld = 1'b1;
    data_in = 45'h1AAAA;
    r_rdy = 1'b0;
    tick();
    data_in = 45'h2BBBB;
    r_rdy = 1'b1;
    @(negedge clk);
    chk("t4_pop0_vld", 64'(r_vld), 64'(1));
    chk("t4_commit", 64'(sram_we), 64'(1));
    tick();
    w_vld = 1'b0;
    @(negedge clk);
    chk("t4_no_bubble", 64'(r_vld), 64'(1));
    chk("t4_data", 64'(data_out), 64'(45'h2BBBB));
    tick();
    r_rdy = 1'b0;
    @(negedge clk);
    chk("t4_empty", 64'(level), 64'(0));

    // Threshold boundary at 5/6 for both packings.
    for (int i = 0; i < 5; i++) begin
      tick();
      w_vld = 1'b1;
      data_in = WIDTH'(100 + i);
    end
    tick();
    w_vld = 1'b0;
    @(negedge clk);
    chk("t5_level5", 64'(level), 64'(5));
    chk("t5_above_at5", 64'(above_th), 64'(0));
    chk("t5_b_above_at5", 64'(b_above), 64'(0));
    tick();
    w_vld = 1'b1;
    data_in = WIDTH'(200);
    tick();
    w_vld = 1'b0;
    @(negedge clk);
    chk("t5_above_at6", 64'(above_th), 64'(1));
    chk("t5_b_above_at6", 64'(b_above), 64'(1));
    chk("t5_b_level6", 64'(b_level), 64'(6));
    tick();
    drain("t5_drained");

    // Reset with level 10 and a fetch in flight.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      tick();
      w_vld = 1'b1;
      data_in = WIDTH'({$urandom(), $urandom()});
    end
    tick();
    w_vld = 1'b0;
    r_rdy = 1'b1;
    tick();
    @(negedge clk);
    chk("t6_fetch_issued", 64'(sram_re), 64'(1));
    tick();
    rst_n = 1'b0;
    r_rdy = 1'b0;
    @(negedge clk);
    chk("t6_level_pre", 64'(level), 64'(10));
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_level_post", 64'(level), 64'(0));
    chk("t6_r_vld_post", 64'(r_vld), 64'(0));
    chk("t6_sram_re_post", 64'(sram_re), 64'(0));
    p0 = pops;
    for (int i = 0; i < 3; i++) begin
      tick();
      w_vld = 1'b1;
      data_in = WIDTH'(45'h777 + i);
    end
    tick();
    w_vld = 1'b0;
    drain("t6_drained");
    tick();
    chk("t6_pops", 64'(pops - p0), 64'(3));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
